fft_stage_quant: RTL and testbench
==================================

// Module: fft_stage_quant
// PURPOSE
// - Parametrised inter-stage quantiser for the parallel FFT datapath: takes P complex samples per beat,
//   drops DROP LSBs with rounding, saturates to NBITS_OUT, and forwards them with the enable strobe.
// - Replaces the fixed-width sat0..sat3 hops between butterfly stages. Adds per-frame overflow reporting
//   and a frame-start marker, derived from a beat counter over N/P beats.
// PARAMETERS
// - NBITS_IN   21   input width per real/imag component, signed two's complement
// - NBITS_OUT  10   output width per component
// - DROP       11   LSBs discarded (0 = no rounding, saturation only)
// - P           4   complex lanes per beat
// - N         128   FFT size in samples; N % P == 0; FRAME_BEATS = N/P
// PORTS
// - clk           in   1                  clock, rising edge
// - rst           in   1                  asynchronous reset, active-high
// - in_enable     in   1                  input beat valid
// - fftIn         in   P*2*NBITS_IN       lane k at [k*2*NBITS_IN +: 2*NBITS_IN]; real = upper half, imag = lower half
// - i_clr_stats   in   1                  synchronous clear of o_sat_cnt
// - o_enable      out  1                  output beat valid
// - fftOut        out  P*2*NBITS_OUT     same packing as fftIn
// - o_frame_start out  1                  high with the first output beat of each frame
// - o_ovf_frame   out  1                  high with the last beat of a frame if any component in it saturated
// BEHAVIOUR
// - Reset: o_enable, o_frame_start, o_ovf_frame = 0; fftOut = 0; beat counter = 0; sticky flag = 0.
//   Reset mid-frame discards the pipeline contents. The first beat after reset starts a new frame.
// - Latency: exactly 2 cycles from in_enable/fftIn to o_enable/fftOut. A gap in in_enable gives a gap in
//   o_enable. Bubbles are allowed anywhere and do not advance the beat counter. There is no backpressure.
// - Stage 1 (registered): r = x + 2^(DROP-1), computed on NBITS_IN+1 bits; then r >>> DROP (arithmetic).
//   This is round-half-up: -1.5 -> -1, +1.5 -> +2. With DROP = 0, r = x.
// - Stage 2 (registered): if r > 2^(NBITS_OUT-1)-1, output MAX; if r < -2^(NBITS_OUT-1), output MIN.
//   Otherwise output r[NBITS_OUT-1:0]. A component is flagged sat when it is clamped.
// - Beat counter: 0..FRAME_BEATS-1, advanced on each stage-2 valid beat, wraps to 0.
//   o_frame_start = valid && cnt == 0.
// - Sticky flag: ORs the sat flags of all 2P components on each valid beat. o_ovf_frame = valid && last
//   beat && (sticky || sat in this beat). The sticky flag clears on the last beat. Lane data registers hold
//   their value when there is no valid beat.
// - Data and enables are not gated by stats logic; stats never stall the datapath.
// CONFIGURATION
// - FFT_QUANT_SATCNT_EN defined: adds o_sat_cnt (out, 16 bits). It counts valid beats with at least one
//   saturated component and stops at 16'hFFFF (no wrap). Reset value is 0. On i_clr_stats it becomes 0,
//   or 1 if the same cycle has a saturating beat.
// - Macro undefined: neither o_sat_cnt nor the counter exists, and i_clr_stats is ignored.
//   Datapath timing is identical in both builds.
// STRUCTURE
// - Package fft_quant_pkg holds:
//   - function clog2
//   - localparams FRAME_BEATS and CNT_W
//   - function sat_round(x, NBITS_IN, NBITS_OUT, DROP), returning {sat, value}, shared by the bench model
// - Sub-module fft_cplx_round_sat: one complex sample, two registered stages plus the per-sample sat flag.
//   It is instantiated P times via generate. The top holds the valid pipe, beat counter, sticky flag and
//   optional counter.
// TESTING (bench config NBITS_IN=12, NBITS_OUT=8, DROP=3, P=2, N=8, so FRAME_BEATS=4)
// - Rounding, lane0 re/im = 12 / 11 -> 2 / 1 two cycles later. Lane1 = -12 / -13 -> -1 / -2. No o_ovf_frame.
// - Saturation, re = 1019 -> 127 with no flag. re = 1020 -> 127 with sat. im = -2048 -> -256 -> -128 with sat.
//   o_ovf_frame is high on beat 3 of that frame and low on the next clean frame.
// - Framing with bubbles: 8 valid beats with in_enable low on every other cycle. o_frame_start pulses on
//   output beats 0 and 4. o_enable mirrors in_enable delayed by 2.
// - Reset mid-frame: assert rst after beat 2, with beat 1 saturated. All outputs go to 0 immediately. After
//   release the next beat has o_frame_start = 1, and the old sat flag never appears.
// - Stats, macro defined: 3 saturating beats -> o_sat_cnt = 3. i_clr_stats together with a saturating beat
//   -> 1. Forcing the count to 16'hFFFF plus one more saturating beat leaves it at FFFF.
// - Compare every output against the fft_quant_pkg::sat_round model for 10k random beats with random
//   in_enable. There must be no mismatches.

Source files
------------

// File: rtl/fft_quant_pkg.sv
// Shared definitions for the inter-stage FFT quantiser.
//   clog2       : ceiling log2, never below 1 so counters always get at least one bit
//   FRAME_BEATS : beats per frame for the default N/P configuration
//   CNT_W       : beat-counter width for the default configuration
//   sat_round   : behavioural round-half-up + saturate of one component, returns {sat, value}
// Optional feature macro used by the top: FFT_QUANT_SATCNT_EN.
package fft_quant_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned FRAME_BEATS = 128 / 4;
    localparam int unsigned CNT_W       = clog2(FRAME_BEATS);

    // x holds an nbits_in-wide two's complement pattern in its low bits; the value field is the
    // result as a 64-bit two's complement number, the top bit is the saturation flag.
    function automatic logic [64:0] sat_round(input longint x, input int nbits_in,
                                              input int nbits_out, input int drop);
        longint xs;
        longint r;
        longint max_v;
        longint min_v;
        logic   sat;
        xs    = (x <<< (64 - nbits_in)) >>> (64 - nbits_in);
        r     = (xs + ((longint'(1) <<< drop) >>> 1)) >>> drop;
        max_v = (longint'(1) <<< (nbits_out - 1)) - 1;
        min_v = -max_v - 1;
        sat   = 1'b0;
        if (r > max_v) begin
            r   = max_v;
            sat = 1'b1;
        end else if (r < min_v) begin
            r   = min_v;
            sat = 1'b1;
        end
        return {sat, r};
    endfunction

endpackage

// File: rtl/fft_cplx_round_sat.sv
// One complex sample of the quantiser: stage 1 rounds (round-half-up, drop DROP LSBs),
// stage 2 saturates to NBITS_OUT and produces the per-sample sat flag.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   s1_en_i   : load stage 1 (input beat valid)
//   s2_en_i   : load stage 2 (stage 1 holds a valid beat)
//   x_i       : {real, imag}, NBITS_IN each, signed
//   y_o       : {real, imag}, NBITS_OUT each, signed
//   sat_o     : either component was clamped in the beat currently on y_o
module fft_cplx_round_sat
    import fft_quant_pkg::*;
#(
    parameter int unsigned NBITS_IN  = 21,
    parameter int unsigned NBITS_OUT = 10,
    parameter int unsigned DROP      = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s1_en_i,
    input  logic                   s2_en_i,
    input  logic [2*NBITS_IN-1:0]  x_i,
    output logic [2*NBITS_OUT-1:0] y_o,
    output logic                   sat_o
);
    // One guard bit so adding the rounding constant can never wrap.
    localparam int unsigned W = NBITS_IN + 1;
    localparam logic signed [W-1:0] Rnd  = W'((2 ** DROP) / 2);
    localparam logic signed [W-1:0] MaxV = W'((2 ** (NBITS_OUT - 1)) - 1);
    localparam logic signed [W-1:0] MinV = ~MaxV;

    logic signed [W-1:0] re_ext, im_ext, re_sum, im_sum;
    logic signed [W-1:0] re_q, re_d, im_q, im_d;
    logic [NBITS_OUT:0]     re_cl, im_cl;
    logic [2*NBITS_OUT-1:0] y_q, y_d;
    logic                   sat_q, sat_d;

    function automatic logic [NBITS_OUT:0] clamp(input logic signed [W-1:0] r);
        logic [NBITS_OUT:0] res;
        if (r > MaxV) begin
            res = {1'b1, MaxV[NBITS_OUT-1:0]};
        end else if (r < MinV) begin
            res = {1'b1, MinV[NBITS_OUT-1:0]};
        end else begin
            res = {1'b0, r[NBITS_OUT-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        re_ext = {x_i[2*NBITS_IN-1], x_i[2*NBITS_IN-1 -: NBITS_IN]};
        im_ext = {x_i[NBITS_IN-1], x_i[NBITS_IN-1:0]};
        re_sum = re_ext + Rnd;
        im_sum = im_ext + Rnd;
        re_d   = s1_en_i ? (re_sum >>> DROP) : re_q;
        im_d   = s1_en_i ? (im_sum >>> DROP) : im_q;
        re_cl  = clamp(re_q);
        im_cl  = clamp(im_q);
        y_d    = s2_en_i ? {re_cl[NBITS_OUT-1:0], im_cl[NBITS_OUT-1:0]} : y_q;
        sat_d  = s2_en_i ? (re_cl[NBITS_OUT] | im_cl[NBITS_OUT]) : sat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q  <= '0;
            im_q  <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            re_q  <= re_d;
            im_q  <= im_d;
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/fft_stage_quant.sv
// Parametrised inter-stage quantiser for the parallel FFT datapath. P complex lanes per beat are
// rounded, saturated and forwarded two cycles later, with frame-start and per-frame overflow marks.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_enable, fftIn      : input beat valid and P packed {real, imag} samples
//   i_clr_stats           : synchronous clear of o_sat_cnt (ignored when the counter is absent)
//   o_enable, fftOut      : output beat valid and quantised samples, same packing
//   o_frame_start         : first output beat of each N/P-beat frame
//   o_ovf_frame           : last beat of a frame in which any component saturated
//   o_sat_cnt             : saturating-beat counter, only with FFT_QUANT_SATCNT_EN defined
module fft_stage_quant
    import fft_quant_pkg::*;
#(
    parameter int unsigned NBITS_IN  = 21,
    parameter int unsigned NBITS_OUT = 10,
    parameter int unsigned DROP      = 11,
    parameter int unsigned P         = 4,
    parameter int unsigned N         = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_enable,
    input  logic [P*2*NBITS_IN-1:0]  fftIn,
    input  logic                     i_clr_stats,
    output logic                     o_enable,
    output logic [P*2*NBITS_OUT-1:0] fftOut,
    output logic                     o_frame_start,
    output logic                     o_ovf_frame
`ifdef FFT_QUANT_SATCNT_EN
    ,
    output logic [15:0]              o_sat_cnt
`endif
);
    localparam int unsigned FrameBeats = N / P;
    localparam int unsigned CntW       = clog2(FrameBeats);
    localparam logic [CntW-1:0] LastBeat = CntW'(FrameBeats - 1);

    logic            v1_q, v1_d, v2_q, v2_d;
    logic [P-1:0]    lane_sat;
    logic            sat_any;
    logic            last_beat;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sticky_q, sticky_d;

    for (genvar k = 0; k < P; k++) begin : g_lane
        fft_cplx_round_sat #(
            .NBITS_IN (NBITS_IN),
            .NBITS_OUT(NBITS_OUT),
            .DROP     (DROP)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .s1_en_i(in_enable),
            .s2_en_i(v1_q),
            .x_i    (fftIn[k*2*NBITS_IN +: 2*NBITS_IN]),
            .y_o    (fftOut[k*2*NBITS_OUT +: 2*NBITS_OUT]),
            .sat_o  (lane_sat[k])
        );
    end

    always_comb begin
        v1_d          = in_enable;
        v2_d          = v1_q;
        sat_any       = |lane_sat;
        last_beat     = (cnt_q == LastBeat);
        cnt_d         = cnt_q;
        sticky_d      = sticky_q;
        if (v2_q) begin
            if (last_beat) begin
                cnt_d    = '0;
                sticky_d = 1'b0;
            end else begin
                cnt_d    = cnt_q + CntW'(1);
                sticky_d = sticky_q | sat_any;
            end
        end
        o_enable      = v2_q;
        o_frame_start = v2_q && (cnt_q == '0);
        // The last beat's own saturation counts, so fold it in before the sticky flag sees it.
        o_ovf_frame   = v2_q && last_beat && (sticky_q || sat_any);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef FFT_QUANT_SATCNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        beat_sat;

    always_comb begin
        beat_sat  = v2_q && sat_any;
        sat_cnt_d = sat_cnt_q;
        if (i_clr_stats) begin
            sat_cnt_d = {15'd0, beat_sat};
        end else if (beat_sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`else
    logic unused_clr_stats;
    assign unused_clr_stats = i_clr_stats;
`endif

endmodule

// File: tb/tb_fft_stage_quant.sv
// Self-checking bench for fft_stage_quant (NBITS_IN=12, NBITS_OUT=8, DROP=3, P=2, N=8).
// Directed rounding/saturation/framing/reset scenarios plus 10k random beats, all compared
// each cycle against a beat-level reference model built on fft_quant_pkg::sat_round.
module tb_fft_stage_quant;
    import fft_quant_pkg::*;

    localparam int NI = 12;
    localparam int NO = 8;
    localparam int DR = 3;
    localparam int P  = 2;
    localparam int N  = 8;
    localparam int FB = N / P;
    localparam int IW = P * 2 * NI;
    localparam int OW = P * 2 * NO;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_enable = 1'b0;
    logic          i_clr_stats = 1'b0;
    logic [IW-1:0] fftIn = '0;
    logic          o_enable, o_frame_start, o_ovf_frame;
    logic [OW-1:0] fftOut;
`ifdef FFT_QUANT_SATCNT_EN
    logic [15:0]   o_sat_cnt;
`endif

    fft_stage_quant #(
        .NBITS_IN (NI),
        .NBITS_OUT(NO),
        .DROP     (DR),
        .P        (P),
        .N        (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_enable    (in_enable),
        .fftIn        (fftIn),
        .i_clr_stats  (i_clr_stats),
        .o_enable     (o_enable),
        .fftOut       (fftOut),
        .o_frame_start(o_frame_start),
        .o_ovf_frame  (o_ovf_frame)
`ifdef FFT_QUANT_SATCNT_EN
        ,
        .o_sat_cnt    (o_sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the beat accepted one edge ago, what the output shows, and frame state.
    logic          s1_en;
    logic [IW-1:0] s1_d;
    logic          m_en, m_fs, m_ovf, m_bsat, frame_sat;
    logic [OW-1:0] m_out;
    int            beat_idx;
    logic [15:0]   m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        s1_en     = 1'b0;
        s1_d      = '0;
        m_en      = 1'b0;
        m_fs      = 1'b0;
        m_ovf     = 1'b0;
        m_bsat    = 1'b0;
        frame_sat = 1'b0;
        m_out     = '0;
        beat_idx  = 0;
        m_cnt     = '0;
    endtask

    task automatic model_edge();
        logic [64:0]   res;
        logic [NI-1:0] comp;
        // Stats see the beat that was on the output before this edge.
        if (i_clr_stats) m_cnt = (m_en && m_bsat) ? 16'd1 : 16'd0;
        else if (m_en && m_bsat && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_en   = s1_en;
        m_fs   = 1'b0;
        m_ovf  = 1'b0;
        m_bsat = 1'b0;
        if (s1_en) begin
            for (int k = 0; k < P; k++) begin
                for (int c = 0; c < 2; c++) begin
                    comp = s1_d[k*2*NI + c*NI +: NI];
                    res  = sat_round(longint'(comp), NI, NO, DR);
                    m_out[k*2*NO + c*NO +: NO] = res[NO-1:0];
                    m_bsat = m_bsat | res[64];
                end
            end
            m_fs      = (beat_idx == 0);
            m_ovf     = (beat_idx == FB - 1) && (frame_sat || m_bsat);
            frame_sat = (beat_idx == FB - 1) ? 1'b0 : (frame_sat | m_bsat);
            beat_idx  = (beat_idx + 1) % FB;
        end
        s1_en = in_enable;
        s1_d  = fftIn;
    endtask

    task automatic compare_all();
        check("enable", 64'(o_enable), 64'(m_en));
        check("data", 64'(fftOut), 64'(m_out));
        check("frame_start", 64'(o_frame_start), 64'(m_fs));
        check("ovf_frame", 64'(o_ovf_frame), 64'(m_ovf));
`ifdef FFT_QUANT_SATCNT_EN
        check("sat_cnt", 64'(o_sat_cnt), 64'(m_cnt));
`endif
    endtask

    task automatic cyc(input logic en, input logic [IW-1:0] d, input logic clr);
        in_enable   = en;
        fftIn       = d;
        i_clr_stats = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [IW-1:0] pack(input int r0, input int i0, input int r1, input int i1);
        logic [NI-1:0] a, b, c, d;
        a = NI'(r1);
        b = NI'(i1);
        c = NI'(r0);
        d = NI'(i0);
        return {a, b, c, d};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_enable", 64'(o_enable), 64'd0);
        check("rst_data", 64'(fftOut), 64'd0);
        check("rst_fs", 64'(o_frame_start), 64'd0);
        check("rst_ovf", 64'(o_ovf_frame), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [IW-1:0] sat_beat;
    int            out_idx;

    initial begin
        model_reset();
        sat_beat = pack(1020, 0, 0, 0);
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Rounding: round-half-up on both signs.
        cyc(1'b1, pack(12, 11, -12, -13), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("round_l0_re", 64'(fftOut[15:8]), 64'h02);
        check("round_l0_im", 64'(fftOut[7:0]), 64'h01);
        check("round_l1_re", 64'(fftOut[31:24]), 64'hFF);
        check("round_l1_im", 64'(fftOut[23:16]), 64'hFE);
        check("round_no_ovf", 64'(o_ovf_frame), 64'd0);

        // Saturation boundary: beats 1..3 of the frame.
        cyc(1'b1, pack(1019, 0, 0, 0), 1'b0);
        cyc(1'b1, pack(1020, 0, 0, 0), 1'b0);
        check("sat_1019", 64'(fftOut[15:8]), 64'h7F);
        cyc(1'b1, pack(0, -2048, 0, 0), 1'b0);
        check("sat_1020", 64'(fftOut[15:8]), 64'h7F);
        cyc(1'b0, '0, 1'b0);
        check("sat_m2048", 64'(fftOut[7:0]), 64'h80);
        check("ovf_beat3", 64'(o_ovf_frame), 64'd1);
        for (int i = 0; i < FB; i++) cyc(1'b1, pack(1, 2, 3, 4), 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("clean_enable", 64'(o_enable), 64'd1);
        check("clean_no_ovf", 64'(o_ovf_frame), 64'd0);
        cyc(1'b0, '0, 1'b0);

        // Framing with bubbles on every other cycle.
        out_idx = 0;
        for (int i = 0; i < 18; i++) begin
            cyc((i < 16) && (i % 2 == 0), pack(i * 7, -i, 2 * i, 5), 1'b0);
            if (o_enable) begin
                check("fs_position", 64'(o_frame_start), 64'((out_idx % FB) == 0));
                out_idx++;
            end
        end
        check("fs_beat_count", 64'(out_idx), 64'd8);

        // Reset mid-frame with a saturated beat pending in the sticky flag.
        cyc(1'b1, pack(1, 1, 1, 1), 1'b0);
        cyc(1'b1, sat_beat, 1'b0);
        cyc(1'b1, pack(1, 1, 1, 1), 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        do_reset();
        out_idx = 0;
        for (int i = 0; i < FB + 2; i++) begin
            cyc(i < FB, pack(3, 3, 3, 3), 1'b0);
            if (o_enable) begin
                if (out_idx == 0) check("post_rst_fs", 64'(o_frame_start), 64'd1);
                if (out_idx == FB - 1) check("post_rst_ovf", 64'(o_ovf_frame), 64'd0);
                out_idx++;
            end
        end
        check("post_rst_beats", 64'(out_idx), 64'(FB));

        // Random beats, random bubbles and occasional stats clears.
        for (int i = 0; i < 10000; i++) begin
            cyc($urandom_range(0, 3) != 0, IW'({$urandom(), $urandom()}),
                $urandom_range(0, 31) == 0);
        end
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);

`ifdef FFT_QUANT_SATCNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, sat_beat, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
        check("satcnt_three", 64'(o_sat_cnt), 64'd3);
        cyc(1'b1, sat_beat, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        check("satcnt_clr_sat", 64'(o_sat_cnt), 64'd1);
        force dut.sat_cnt_q = 16'hFFFF;
        #1;
        release dut.sat_cnt_q;
        m_cnt = 16'hFFFF;
        cyc(1'b1, sat_beat, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
        check("satcnt_hold_max", 64'(o_sat_cnt), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
